// File: rtl/tick_pulse_gen.sv
// Event-to-pulse stretcher: each accepted tick yields one ON_CYC-long high pulse
// followed by at least GAP_CYC low cycles; extra ticks are queued up to PEND_MAX.
module tick_pulse_gen #(
  parameter int CLK_FREQ      = 27_000_000,
  parameter int PULSE_TIME_MS = 50,
  parameter int GAP_TIME_MS   = 50,
  parameter int PEND_MAX      = 7
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          tick_in,
  input  logic                          clear,
  output logic                          level_out,
  output logic                          busy,
  output logic [$clog2(PEND_MAX+1)-1:0] pending,
  output logic                          done_tick,
  output logic                          overflow
);

  localparam int ON_CYC  = (CLK_FREQ / 1000) * PULSE_TIME_MS;
  localparam int GAP_CYC = (CLK_FREQ / 1000) * GAP_TIME_MS;
  localparam int MAX_CYC = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int PW      = $clog2(PEND_MAX + 1);

  localparam logic [CW-1:0] ON_LD  = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYC - 1);
  localparam logic [PW-1:0] P_MAX  = PW'(PEND_MAX);

  // ON is the only encoding with bit 0 set, so level_out is a single flop bit
  // and cannot glitch on ON->GAP transitions.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ON   = 2'b01,
    GAP  = 2'b10
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_pend;

  logic w_cnt_zero;
  logic w_last_gap;
  logic w_full;
  logic w_queue;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_last_gap = (r_state == GAP) && w_cnt_zero;
  assign w_full     = (r_pend == P_MAX);
  // A tick in the final gap cycle starts the next pulse directly instead of queueing.
  assign w_queue    = tick_in && !clear && (r_state != IDLE) && !w_last_gap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
    end else if (clear) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
    end else begin
      if (w_queue && !w_full) r_pend <= r_pend + 1'b1;
      case (r_state)
        IDLE: begin
          if (tick_in) begin
            r_state <= ON;
            r_cnt   <= ON_LD;
          end
        end
        ON: begin
          if (w_cnt_zero) begin
            r_state <= GAP;
            r_cnt   <= GAP_LD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        GAP: begin
          if (w_cnt_zero) begin
            if (tick_in) begin
              r_state <= ON;
              r_cnt   <= ON_LD;
            end else if (r_pend != '0) begin
              r_state <= ON;
              r_cnt   <= ON_LD;
              r_pend  <= r_pend - 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign level_out = r_state[0];
  assign busy      = (r_state != IDLE);
  assign pending   = r_pend;
  assign done_tick = (r_state == ON) && w_cnt_zero && !clear;
  assign overflow  = w_queue && w_full;

endmodule
